// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch address generation, single
// outstanding req/ack memory handshake, and a PC-tagged FIFO feeding IF/ID.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        hold,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_after_pop;
   logic [CNT_W-1:0]   count_after_push_pop;

   logic [31:0]        fifo_pc_mem   [DEPTH];
   logic [31:0]        fifo_inst_mem [DEPTH];

   logic               pop;
   logic               push;
   logic               flush;

   // A pop needs a live head, no stall, and no redirect killing the head.
   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid && !hold && !redirect;

   // Occupancy seen by the request decision once this cycle's traffic lands.
   assign count_after_pop      = count_q - CNT_W'(pop);
   assign count_after_push_pop = count_q + CNT_W'(1) - CNT_W'(pop);

   assign inst_out = inst_valid ? fifo_inst_mem[rd_ptr_q] : 32'h0;
   assign inst_pc  = inst_valid ? fifo_pc_mem[rd_ptr_q]   : 32'h0;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

   // Next-state and handshake decisions; redirect outranks push and pop.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      flush      = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_pc;
            end else if (count_after_pop < FULL_CNT) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_pc;
               if (mem_ack) begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end else begin
                  // The request cannot be withdrawn; wait out its ack.
                  state_d   = DROP;
               end
            end else if (mem_ack) begin
               push       = 1'b1;
               fetch_pc_d = mem_addr_q + 32'd4;
               if (count_after_push_pop < FULL_CNT) begin
                  mem_addr_d = mem_addr_q + 32'd4;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end
         end
         DROP: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_pc;
            end
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Control registers, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'h0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // FIFO storage; contents are don't-care until count marks them live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_mem[wr_ptr_q]   <= mem_addr_q;
         fifo_inst_mem[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a variable-latency memory model.
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        hold = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   int lat   = 0;
   int wcnt  = 0;
   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd3) ^ 32'hC0DE_0000;
   endfunction

   fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hold        (hold),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .inst_valid  (inst_valid),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc)
   );

   always #5 clk = ~clk;

   // Memory model: acks after 'lat' wait cycles, data is a function of address.
   assign mem_ack   = mem_req && (wcnt >= lat);
   assign mem_rdata = mem_word(mem_addr);

   always @(posedge clk) begin
      if (!mem_req || mem_ack) wcnt <= 0;
      else                     wcnt <= wcnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, got);
      end
   endtask

   task automatic wait_addr(input logic [31:0] a, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == a) found = 1'b1;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (inst_valid) found = 1'b1;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_ack(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_ack) found = 1'b1;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset values and streaming with zero-wait memory
      repeat (2) @(negedge clk);
      check("rst_mem_req",    32'(mem_req),    32'd0);
      check("rst_mem_addr",   mem_addr,        32'h0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_out",   inst_out,        32'h0);
      check("rst_inst_pc",    inst_pc,         32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("c1_mem_req",    32'(mem_req),    32'd1);
      check("c1_mem_addr",   mem_addr,        32'h0);
      check("c1_inst_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stream_valid", 32'(inst_valid), 32'd1);
         check("stream_pc",    inst_pc,         32'(4 * i));
         check("stream_inst",  inst_out,        mem_word(32'(4 * i)));
      end

      // 2: hold saturates the queue at four entries
      rst = 1'b1;
      hold = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("hold_req_c4",  32'(mem_req), 32'd1);
      check("hold_addr_c4", mem_addr,     32'hC);
      @(negedge clk);
      check("hold_full_req", 32'(mem_req), 32'd0);
      repeat (3) @(negedge clk);
      check("hold_stay_req", 32'(mem_req),    32'd0);
      check("hold_head_vld", 32'(inst_valid), 32'd1);
      check("hold_head_pc",  inst_pc,         32'h0);
      hold = 1'b0;
      @(negedge clk);
      check("unhold_req",  32'(mem_req), 32'd1);
      check("unhold_addr", mem_addr,     32'h10);
      check("unhold_pc",   inst_pc,      32'h4);
      @(negedge clk);
      check("unhold_pc2",  inst_pc,      32'h8);

      // 3: redirect while a slow request is pending
      rst = 1'b1;
      lat = 3;
      @(negedge clk);
      rst = 1'b0;
      wait_addr(32'h8, "lat_reach8");
      redirect = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect = 1'b0;
      check("drop_req_b",   32'(mem_req),    32'd1);
      check("drop_addr_b",  mem_addr,        32'h8);
      check("drop_valid_b", 32'(inst_valid), 32'd0);
      @(negedge clk);
      check("drop_addr_c",  mem_addr,        32'h8);
      @(negedge clk);
      check("drop_ack_d",   32'(mem_ack),    32'd1);
      check("drop_addr_d",  mem_addr,        32'h8);
      @(negedge clk);
      check("drop_idle_req", 32'(mem_req),    32'd0);
      check("drop_no_push",  32'(inst_valid), 32'd0);
      @(negedge clk);
      check("redir_req",  32'(mem_req), 32'd1);
      check("redir_addr", mem_addr,     32'h100);
      wait_valid("redir_valid");
      check("redir_pc",   inst_pc,  32'h100);
      check("redir_inst", inst_out, mem_word(32'h100));

      // 4: redirect coinciding with an ack
      lat = 2;
      wait_ack("ack_seen");
      redirect = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect = 1'b0;
      check("ackredir_valid", 32'(inst_valid), 32'd0);
      check("ackredir_req",   32'(mem_req),    32'd0);
      @(negedge clk);
      check("ackredir_req2",  32'(mem_req), 32'd1);
      check("ackredir_addr",  mem_addr,     32'h40);
      wait_valid("ackredir_vld");
      check("ackredir_pc",    inst_pc,  32'h40);
      check("ackredir_inst",  inst_out, mem_word(32'h40));

      // 5: flush of a two-entry queue
      rst = 1'b1;
      hold = 1'b1;
      lat = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("two_valid", 32'(inst_valid), 32'd1);
      check("two_pc",    inst_pc,         32'h0);
      check("two_addr",  mem_addr,        32'h8);
      hold = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect = 1'b0;
      check("flush_valid", 32'(inst_valid), 32'd0);
      check("flush_pc",    inst_pc,         32'h0);
      check("flush_inst",  inst_out,        32'h0);
      check("flush_req",   32'(mem_req),    32'd0);
      @(negedge clk);
      check("flush_addr",  mem_addr, 32'h200);
      @(negedge clk);
      check("flush_newpc", inst_pc,  32'h200);

      // 6: asynchronous reset in the middle of a request
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_addr(32'h20, "arst_reach20");
      lat = 7;
      check("arst_pre_valid", 32'(inst_valid), 32'd1);
      check("arst_pre_pc",    inst_pc,         32'h1C);
      #2;
      rst = 1'b1;
      #1;
      check("arst_req",   32'(mem_req),    32'd0);
      check("arst_addr",  mem_addr,        32'h0);
      check("arst_valid", 32'(inst_valid), 32'd0);
      check("arst_inst",  inst_out,        32'h0);
      check("arst_pc",    inst_pc,         32'h0);
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      @(negedge clk);
      check("arst_rel_req",  32'(mem_req), 32'd1);
      check("arst_rel_addr", mem_addr,     32'h0);
      @(negedge clk);
      check("arst_rel_pc",   inst_pc,  32'h0);
      check("arst_rel_inst", inst_out, mem_word(32'h0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
